fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage, directly upstream of the decoder. It holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents each fetched 32-bit instruction with a valid strobe that drives the decoder's enable. It stops permanently when the decoder flags HLT, and it accepts single-cycle PC redirects from the execute stage.

## Interface
Parameters:
- ADDR_W, 16: byte-address width of the PC and the memory address.
- RESET_PC, 0: first fetch address after reset. Must be word-aligned.

Ports:
- clk  in  1  the only clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request; the address is stable while it is high.
- imem_addr  out  ADDR_W  word-aligned byte address; bits [1:0] are always 0.
- imem_ack  in  1  read-data-valid; meaningful only while imem_req=1.
- imem_rdata  in  32  instruction word, sampled when req&ack.
- instr  out  32  registered instruction; goes to the decoder's instr input.
- en  out  1  instr valid; goes to the decoder's enable.
- dec_ready  in  1  downstream accepts instr this cycle.
- halt  in  1  decoder HLT flag (opcode 6'b001011); sampled only while en=1.
- redirect  in  1  single-cycle request to load a new PC.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] are ignored and forced to 0.
- pc  out  ADDR_W  address of the instruction currently on instr.
- halted  out  1  high in the HALTED state.

## Operation
- The state machine has four states: IDLE, FETCH, VALID, HALTED. The reset state is IDLE.
- IDLE: no request. Moves to FETCH on the next cycle.
- FETCH: imem_req=1 and imem_addr=fetch_pc.
  - On imem_ack: instr<=imem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+4, then go to VALID.
  - With no ack, stay in FETCH and hold the address.
- VALID: en=1 and imem_req=0.
  - dec_ready=1 and halt=1: go to HALTED.
  - dec_ready=1 and halt=0: go to FETCH.
  - dec_ready=0: hold instr, pc and en.
- HALTED: en=0 and imem_req=0. Only rst leaves this state.
- Priority in any non-HALTED state is redirect > halt > ack/ready.
  - On redirect: fetch_pc<={redirect_pc[ADDR_W-1:2],2'b00}, go to FETCH, en drops next cycle.
  - Any ack in the same cycle is discarded: instr and pc are not updated.
- Redirect while HALTED is ignored.
- fetch_pc increments modulo 2^ADDR_W; address 2^ADDR_W-4 wraps to 0.
- Memory contract: the memory may not assume a request completes. Dropping imem_req after a redirect is legal, and an ack seen while req=0 is ignored.
- halt is honoured only in VALID together with dec_ready. halt asserted while en=0 has no effect.

## Timing
- Values while rst=1 and in the cycle after:
  - imem_req=0, en=0, halted=0
  - instr=32'h0, pc=RESET_PC, fetch_pc=RESET_PC
- The first imem_req is high in the 2nd cycle after rst falls.
- Fetch latency: ack in cycle N gives en=1 with the new instr in cycle N+1.
- Best-case throughput is one instruction per 2 cycles (FETCH then VALID). Each memory wait cycle adds one.
- Redirect in cycle N gives imem_req=1 with imem_addr=redirect target in cycle N+1.
- HLT accepted in cycle N gives halted=1 and en=0 in cycle N+1.
- rst in any state, including mid-request or HALTED, returns to the reset values on the next edge.

## Structure
- The shared package cpu_pkg holds:
  - INSTR_W=32
  - OP_HLT=6'b001011
  - the instruction field positions (pfix[31:30], opcode[29:24], rs[23:20], rd[19:16], imm[15:0])
  - the fetch_state_t enum {IDLE, FETCH, VALID, HALTED}
- Single module with no sub-modules: the FSM, the fetch_pc, pc and instr registers, and the PC incrementer.

## Test plan
- Reset release, RESET_PC=0, memory acks the same cycle:
  - addresses 0, 4, 8 are issued on cycles 2, 4, 6;
  - instr equals the memory word with en=1 on cycles 3, 5, 7;
  - pc reads 0, 4, 8.
- Memory delays ack by 3 cycles: imem_addr is held stable with req=1 for 4 cycles, and en rises the cycle after the ack.
- dec_ready held low for 5 cycles in VALID: instr, pc and en are unchanged and no imem_req is issued.
- Redirect to 16'h0102 in the same cycle as an ack at address 8:
  - the acked data is dropped;
  - the next request is to 16'h0100;
  - pc shows 16'h0100 when en next rises.
- Decoder halt=1 with dec_ready on the instruction at pc=12:
  - next cycle halted=1 and en=0, with no further imem_req for 20 cycles;
  - a redirect pulse is ignored;
  - rst restarts fetching at RESET_PC.
- ADDR_W=8, fetching from 8'hFC: the next request is to 8'h00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction word layout, HLT opcode and fetch FSM states.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam logic [5:0] OP_HLT = 6'b001011;

    // Instruction field positions: pfix[31:30] opcode[29:24] rs[23:20] rd[19:16] imm[15:0]
    localparam int PFIX_HI = 31;
    localparam int PFIX_LO = 30;
    localparam int OP_HI   = 29;
    localparam int OP_LO   = 24;
    localparam int RS_HI   = 23;
    localparam int RS_LO   = 20;
    localparam int RD_HI   = 19;
    localparam int RD_LO   = 16;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        VALID  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack word reads from instruction memory,
// registered instruction output to the decoder, HLT stop and PC redirects.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               en,
    input  logic               dec_ready,
    input  logic               halt,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    fetch_state_t       r_state;
    logic               r_req;
    logic               r_en;
    logic               r_halted;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;

    logic [ADDR_W-1:0]  w_redirect_tgt;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic               w_unused;

    assign w_redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_pc_inc       = r_fetch_pc + ADDR_W'(4);
    assign w_unused       = &{1'b0, redirect_pc[1:0]};

    // Redirect beats halt beats ack/ready; a redirect discards any same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_en       <= 1'b0;
            r_halted   <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                    if (redirect)
                        r_fetch_pc <= w_redirect_tgt;
                end
                FETCH: begin
                    if (redirect) begin
                        r_fetch_pc <= w_redirect_tgt;
                    end else if (imem_ack) begin
                        r_instr    <= imem_rdata;
                        r_pc       <= r_fetch_pc;
                        r_fetch_pc <= w_pc_inc;
                        r_req      <= 1'b0;
                        r_en       <= 1'b1;
                        r_state    <= VALID;
                    end
                end
                VALID: begin
                    if (redirect) begin
                        r_fetch_pc <= w_redirect_tgt;
                        r_en       <= 1'b0;
                        r_req      <= 1'b1;
                        r_state    <= FETCH;
                    end else if (dec_ready) begin
                        r_en <= 1'b0;
                        if (halt) begin
                            r_halted <= 1'b1;
                            r_state  <= HALTED;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_fetch_pc;
    assign instr     = r_instr;
    assign en        = r_en;
    assign pc        = r_pc;
    assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a memory model acks requests, every accepted
// ack queues {addr, data}, and each rising en pops and compares instr/pc.
module tb_fetch_unit;
    import cpu_pkg::*;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] data;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        en;
    logic        dec_ready;
    logic        halt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc;
    logic        halted;

    logic        req8, ack8, en8, halted8;
    logic [7:0]  addr8, pc8;
    logic [31:0] rdata8, instr8;
    logic        dec_ready8, halt8, redirect8;
    logic [7:0]  redirect_pc8;

    int  checks = 0;
    int  errors = 0;
    int  ack_delay = 0;
    int  wait_cnt = 0;
    bit  mem_on = 1'b1;
    bit  prev_en = 1'b0;
    sb_t sb_q[$];

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .en(en),
        .dec_ready(dec_ready), .halt(halt), .redirect(redirect),
        .redirect_pc(redirect_pc), .pc(pc), .halted(halted)
    );

    fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFC)) u_dut8 (
        .clk(clk), .rst(rst), .imem_req(req8), .imem_addr(addr8),
        .imem_ack(ack8), .imem_rdata(rdata8), .instr(instr8), .en(en8),
        .dec_ready(dec_ready8), .halt(halt8), .redirect(redirect8),
        .redirect_pc(redirect_pc8), .pc(pc8), .halted(halted8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mword(input logic [15:0] a);
        return {a ^ 16'h5A3C, a};
    endfunction

    // Memory model: acks after ack_delay wait cycles; the 8-bit instance acks at once.
    initial begin
        imem_ack = 1'b0; imem_rdata = '0; ack8 = 1'b0; rdata8 = '0;
        forever begin
            @(negedge clk);
            if (imem_req && mem_on) begin
                if (wait_cnt >= ack_delay) begin
                    imem_ack = 1'b1; imem_rdata = mword(imem_addr); wait_cnt = 0;
                end else begin
                    imem_ack = 1'b0; wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0; wait_cnt = 0;
            end
            ack8   = req8;
            rdata8 = {24'hC3C3C3, addr8};
        end
    end

    always @(posedge clk)
        if (!rst && imem_req && imem_ack && !redirect)
            sb_q.push_back({imem_addr, imem_rdata});

    initial begin
        sb_t exp;
        forever begin
            @(negedge clk);
            if (!rst && en && !prev_en) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop: en rose with pc=%h instr=%h but no accepted fetch pending", pc, instr);
                end else begin
                    exp = sb_q.pop_front();
                    if (instr !== exp.data || pc !== exp.pc) begin
                        errors++;
                        $display("FAIL sb_pop: got pc=%h instr=%h, expected pc=%h instr=%h", pc, instr, exp.pc, exp.data);
                    end
                end
            end
            prev_en = en;
        end
    end

    task automatic apply_reset();
        rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        sb_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; dec_ready = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || en !== 1'b0 || halted !== 1'b0 || instr !== 32'h0 ||
            pc !== 16'h0 || imem_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_vals: req=%b en=%b halted=%b instr=%h pc=%h addr=%h, expected 0 0 0 0 0 0",
                     imem_req, en, halted, instr, pc, imem_addr);
        end
        checks++;
        if (pc8 !== 8'hFC || addr8 !== 8'hFC || req8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals8: pc8=%h addr8=%h req8=%b, expected fc fc 0", pc8, addr8, req8);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        ack_delay = 0; dec_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || en !== 1'b0) begin
            errors++;
            $display("FAIL stream_c1: req=%b en=%b, expected 0 0", imem_req, en);
        end
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if (c % 2 == 0) begin
                if (imem_req !== 1'b1 || en !== 1'b0 || imem_addr !== 16'((c - 2) * 2)) begin
                    errors++;
                    $display("FAIL stream_req c%0d: req=%b en=%b addr=%h, expected 1 0 %h",
                             c, imem_req, en, imem_addr, 16'((c - 2) * 2));
                end
            end else begin
                if (en !== 1'b1 || imem_req !== 1'b0 || pc !== 16'((c - 3) * 2)) begin
                    errors++;
                    $display("FAIL stream_valid c%0d: en=%b req=%b pc=%h, expected 1 0 %h",
                             c, en, imem_req, pc, 16'((c - 3) * 2));
                end
            end
        end
    endtask

    task automatic test_wait_states();
        int count = 0;
        apply_reset();
        ack_delay = 3; dec_ready = 1'b1; halt = 1'b1;
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
        while (imem_req === 1'b1 && count < 10) begin
            checks++;
            if (imem_addr !== 16'h0) begin
                errors++;
                $display("FAIL wait_addr: addr=%h during wait, expected 0000", imem_addr);
            end
            count++;
            @(negedge clk);
        end
        halt = 1'b0;
        checks++;
        if (count !== 4) begin
            errors++;
            $display("FAIL wait_len: req high for %0d cycles, expected 4", count);
        end
        checks++;
        if (en !== 1'b1 || pc !== 16'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL wait_en: en=%b pc=%h halted=%b, expected 1 0000 0", en, pc, halted);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h4 || halted !== 1'b0) begin
            errors++;
            $display("FAIL wait_next: req=%b addr=%h halted=%b, expected 1 0004 0", imem_req, imem_addr, halted);
        end
        ack_delay = 0;
    endtask

    task automatic test_stall();
        apply_reset();
        ack_delay = 0; dec_ready = 1'b0;
        for (int i = 0; i < 20 && en !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (en !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0 || instr !== mword(16'h0)) begin
                errors++;
                $display("FAIL stall_hold %0d: en=%b req=%b pc=%h instr=%h, expected 1 0 0000 %h",
                         i, en, imem_req, pc, instr, mword(16'h0));
            end
            @(negedge clk);
        end
        dec_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h4 || en !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: req=%b addr=%h en=%b, expected 1 0004 0", imem_req, imem_addr, en);
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        ack_delay = 0; dec_ready = 1'b1;
        for (int i = 0; i < 40 && !(imem_req === 1'b1 && imem_addr === 16'h8); i++) @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h8) begin
            errors++;
            $display("FAIL redir_reach: req=%b addr=%h, expected 1 0008", imem_req, imem_addr);
        end
        redirect = 1'b1; redirect_pc = 16'h0102;
        @(negedge clk);
        redirect = 1'b0; redirect_pc = '0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0100 || en !== 1'b0) begin
            errors++;
            $display("FAIL redir_req: req=%b addr=%h en=%b, expected 1 0100 0", imem_req, imem_addr, en);
        end
        @(negedge clk);
        checks++;
        if (en !== 1'b1 || pc !== 16'h0100 || instr !== mword(16'h0100)) begin
            errors++;
            $display("FAIL redir_valid: en=%b pc=%h instr=%h, expected 1 0100 %h", en, pc, instr, mword(16'h0100));
        end
    endtask

    task automatic test_halt();
        apply_reset();
        ack_delay = 0; dec_ready = 1'b1;
        for (int i = 0; i < 40 && !(en === 1'b1 && pc === 16'd12); i++) @(negedge clk);
        checks++;
        if (en !== 1'b1 || pc !== 16'd12) begin
            errors++;
            $display("FAIL halt_reach: en=%b pc=%h, expected 1 000c", en, pc);
        end
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        checks++;
        if (halted !== 1'b1 || en !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: halted=%b en=%b req=%b, expected 1 0 0", halted, en, imem_req);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin redirect = 1'b1; redirect_pc = 16'h0040; end
            if (i == 6) begin redirect = 1'b0; redirect_pc = '0; end
            checks++;
            if (imem_req !== 1'b0 || halted !== 1'b1 || en !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold %0d: req=%b halted=%b en=%b, expected 0 1 0", i, imem_req, halted, en);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || en !== 1'b0 || imem_req !== 1'b0 || pc !== 16'h0) begin
            errors++;
            $display("FAIL halt_reset: halted=%b en=%b req=%b pc=%h, expected 0 0 0 0000", halted, en, imem_req, pc);
        end
        sb_q.delete();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
            errors++;
            $display("FAIL halt_restart: req=%b addr=%h, expected 1 0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        @(negedge clk);
        checks++;
        if (req8 !== 1'b1 || addr8 !== 8'hFC) begin
            errors++;
            $display("FAIL wrap_first: req8=%b addr8=%h, expected 1 fc", req8, addr8);
        end
        @(negedge clk);
        checks++;
        if (en8 !== 1'b1 || pc8 !== 8'hFC || instr8 !== 32'hC3C3C3FC) begin
            errors++;
            $display("FAIL wrap_valid: en8=%b pc8=%h instr8=%h, expected 1 fc c3c3c3fc", en8, pc8, instr8);
        end
        @(negedge clk);
        checks++;
        if (req8 !== 1'b1 || addr8 !== 8'h00) begin
            errors++;
            $display("FAIL wrap_next: req8=%b addr8=%h, expected 1 00", req8, addr8);
        end
    endtask

    task automatic test_drain();
        mem_on = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d accepted fetches never presented, expected 0", sb_q.size());
        end
    endtask

    initial begin
        dec_ready8 = 1'b1; halt8 = 1'b0; redirect8 = 1'b0; redirect_pc8 = '0;
        test_reset();
        test_stream();
        test_wait_states();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
